// File: rtl/pipelined_mac_expr.sv
// pipelined_mac_expr: 5-stage pipelined multiply-accumulate expression unit.
// y = (a!=0) ? (s2+s1) : (s2-p2); p1=a*b, p2=c*d, p3=p1[W-1:0]*e,
// s1=p1+p2, s2=s1+p3. Sums wrap mod 2^2W; define PMAC_SAT_EN to clamp.
// Ports: clk, rst (sync, active-high); a..e operands [W]; in_tag [TAG_W];
//        in_valid/in_ready input handshake; y [2W], out_tag, out_ovf,
//        out_valid/out_ready output handshake; busy = any stage valid.
module pipelined_mac_expr #(
    parameter int W     = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [W-1:0]     c,
    input  logic [W-1:0]     d,
    input  logic [W-1:0]     e,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2*W-1:0]   y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int PW = 2 * W;

    typedef logic [PW-1:0] prod_t;

    function automatic prod_t zx(input logic [W-1:0] v);
        return {{W{1'b0}}, v};
    endfunction

    // Stage 1: products, select captured at acceptance, e carried for p3
    logic             r_s1_v;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_sel;
    prod_t            r_s1_p1;
    prod_t            r_s1_p2;
    logic [W-1:0]     r_s1_e;

    // Stage 2: p3 and s1
    logic             r_s2_v;
    logic [TAG_W-1:0] r_s2_tag;
    logic             r_s2_sel;
    logic             r_s2_ovf;
    prod_t            r_s2_s1;
    prod_t            r_s2_p2;
    prod_t            r_s2_p3;

    // Stage 3: s2
    logic             r_s3_v;
    logic [TAG_W-1:0] r_s3_tag;
    logic             r_s3_sel;
    logic             r_s3_ovf;
    prod_t            r_s3_s1;
    prod_t            r_s3_p2;
    prod_t            r_s3_s2;

    // Stage 4: final add/subtract
    logic             r_s4_v;
    logic [TAG_W-1:0] r_s4_tag;
    logic             r_s4_ovf;
    prod_t            r_s4_y;

    // Stage 5: output register
    logic             r_s5_v;
    logic [TAG_W-1:0] r_s5_tag;
    logic             r_s5_ovf;
    prod_t            r_s5_y;

    logic             w_adv;
    prod_t            w_p1;
    prod_t            w_p2;
    prod_t            w_p3;
    logic [PW:0]      w_s1_sum;
    prod_t            w_s1;
    logic [PW:0]      w_s2_sum;
    prod_t            w_s2;
    logic [PW:0]      w_add;
    logic [PW:0]      w_sub;
    prod_t            w_y4;
    logic             w_ovf4;

    // Whole pipeline moves together; only a blocked output stalls it.
    assign w_adv    = !(r_s5_v && !out_ready);
    assign in_ready = w_adv;

    assign w_p1 = zx(a) * zx(b);
    assign w_p2 = zx(c) * zx(d);
    assign w_p3 = zx(r_s1_p1[W-1:0]) * zx(r_s1_e);

    always_comb begin
        w_s1_sum = {1'b0, r_s1_p1} + {1'b0, r_s1_p2};
        w_s1     = w_s1_sum[PW-1:0];
`ifdef PMAC_SAT_EN
        if (w_s1_sum[PW]) w_s1 = '1;
`endif
    end

    always_comb begin
        w_s2_sum = {1'b0, r_s2_s1} + {1'b0, r_s2_p3};
        w_s2     = w_s2_sum[PW-1:0];
`ifdef PMAC_SAT_EN
        if (w_s2_sum[PW]) w_s2 = '1;
`endif
    end

    // Bit PW of the subtract result is the borrow.
    always_comb begin
        w_add = {1'b0, r_s3_s2} + {1'b0, r_s3_s1};
        w_sub = {1'b0, r_s3_s2} - {1'b0, r_s3_p2};
        if (r_s3_sel) begin
            w_y4   = w_add[PW-1:0];
            w_ovf4 = w_add[PW];
`ifdef PMAC_SAT_EN
            if (w_add[PW]) w_y4 = '1;
`endif
        end else begin
            w_y4   = w_sub[PW-1:0];
            w_ovf4 = w_sub[PW];
`ifdef PMAC_SAT_EN
            if (w_sub[PW]) w_y4 = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s1_tag <= '0;
            r_s1_sel <= 1'b0;
            r_s1_p1  <= '0;
            r_s1_p2  <= '0;
            r_s1_e   <= '0;
            r_s2_v   <= 1'b0;
            r_s2_tag <= '0;
            r_s2_sel <= 1'b0;
            r_s2_ovf <= 1'b0;
            r_s2_s1  <= '0;
            r_s2_p2  <= '0;
            r_s2_p3  <= '0;
            r_s3_v   <= 1'b0;
            r_s3_tag <= '0;
            r_s3_sel <= 1'b0;
            r_s3_ovf <= 1'b0;
            r_s3_s1  <= '0;
            r_s3_p2  <= '0;
            r_s3_s2  <= '0;
            r_s4_v   <= 1'b0;
            r_s4_tag <= '0;
            r_s4_ovf <= 1'b0;
            r_s4_y   <= '0;
            r_s5_v   <= 1'b0;
            r_s5_tag <= '0;
            r_s5_ovf <= 1'b0;
            r_s5_y   <= '0;
        end else if (w_adv) begin
            r_s1_v   <= in_valid;
            r_s1_tag <= in_tag;
            r_s1_sel <= (a != '0);
            r_s1_p1  <= w_p1;
            r_s1_p2  <= w_p2;
            r_s1_e   <= e;

            r_s2_v   <= r_s1_v;
            r_s2_tag <= r_s1_tag;
            r_s2_sel <= r_s1_sel;
            r_s2_ovf <= w_s1_sum[PW];
            r_s2_s1  <= w_s1;
            r_s2_p2  <= r_s1_p2;
            r_s2_p3  <= w_p3;

            r_s3_v   <= r_s2_v;
            r_s3_tag <= r_s2_tag;
            r_s3_sel <= r_s2_sel;
            r_s3_ovf <= r_s2_ovf | w_s2_sum[PW];
            r_s3_s1  <= r_s2_s1;
            r_s3_p2  <= r_s2_p2;
            r_s3_s2  <= w_s2;

            r_s4_v   <= r_s3_v;
            r_s4_tag <= r_s3_tag;
            r_s4_ovf <= r_s3_ovf | w_ovf4;
            r_s4_y   <= w_y4;

            r_s5_v   <= r_s4_v;
            r_s5_tag <= r_s4_tag;
            r_s5_ovf <= r_s4_ovf;
            r_s5_y   <= r_s4_y;
        end
    end

    assign y         = r_s5_y;
    assign out_tag   = r_s5_tag;
    assign out_ovf   = r_s5_ovf;
    assign out_valid = r_s5_v;
    assign busy      = r_s1_v | r_s2_v | r_s3_v | r_s4_v | r_s5_v;

endmodule

// File: tb/tb_pipelined_mac_expr.sv
// tb_pipelined_mac_expr: directed + random bench with an arithmetic
// reference model and in-order scoreboard for pipelined_mac_expr.
module tb_pipelined_mac_expr;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam logic [127:0] LIM = 128'h1_0000_0000_0000_0000;
`ifdef PMAC_SAT_EN
    localparam bit SAT = 1'b1;
    localparam logic [63:0] Y_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    localparam bit SAT = 1'b0;
    localparam logic [63:0] Y_ONES = 64'hFFFF_FFF9_0000_0003;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b, c, d, e;
    logic [TW-1:0] in_tag;
    logic          in_valid;
    logic          in_ready;
    logic [2*W-1:0] y;
    logic [TW-1:0] out_tag;
    logic          out_ovf;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    pipelined_mac_expr #(.W(W), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d), .e(e),
        .in_tag(in_tag), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .out_tag(out_tag), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]   y;
        logic [TW-1:0] tag;
        logic          ovf;
    } res_t;

    res_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;
    int   n_ret = 0;

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Clamp-or-wrap for a value that may exceed 2^64-1.
    function automatic logic [127:0] fix(input logic [127:0] v,
                                         inout logic ovf);
        if (v >= LIM) begin
            ovf = 1'b1;
            return SAT ? LIM - 1 : v - LIM;
        end
        return v;
    endfunction

    function automatic res_t model(input logic [31:0] ma, mb, mc, md, me,
                                   input logic [TW-1:0] t);
        logic [127:0] p1, p2, p3, s1, s2, r;
        logic ovf;
        res_t o;
        ovf = 1'b0;
        p1 = 128'(ma) * 128'(mb);
        p2 = 128'(mc) * 128'(md);
        p3 = (p1 % 128'h1_0000_0000) * 128'(me);
        s1 = fix(p1 + p2, ovf);
        s2 = fix(s1 + p3, ovf);
        if (ma != 0) r = fix(s2 + s1, ovf);
        else if (s2 < p2) begin
            ovf = 1'b1;
            r = SAT ? 128'd0 : s2 + LIM - p2;
        end else r = s2 - p2;
        o.y = r[63:0];
        o.tag = t;
        o.ovf = ovf;
        return o;
    endfunction

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 3))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_ops();
        a = rnd(); b = rnd(); c = rnd(); d = rnd(); e = rnd();
        in_tag = TW'($urandom);
    endtask

    // One clock: check handshake, score retire, record accept.
    task automatic step(output bit acc);
        bit ret;
        res_t r;
        #1;
        chk("in_ready_eq", 64'(in_ready), 64'(!(out_valid && !out_ready)));
        acc = in_valid && in_ready && !rst;
        ret = out_valid && out_ready && !rst;
        if (ret) begin
            n_ret++;
            chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                r = exp_q.pop_front();
                chk("sb_y", y, r.y);
                chk("sb_tag", 64'(out_tag), 64'(r.tag));
                chk("sb_ovf", 64'(out_ovf), 64'(r.ovf));
            end
        end
        if (acc) exp_q.push_back(model(a, b, c, d, e, in_tag));
        @(posedge clk);
        #1;
    endtask

    // Called right after the accepting step; counts edges incl. acceptance.
    task automatic wait_out(input string name);
        int lat;
        bit acc;
        lat = 1;
        while (!out_valid && lat < 12) begin
            step(acc);
            lat++;
        end
        chk({name, "_lat"}, 64'(lat), 64'd5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc;
        int issued, stall, ret0, bad;
        bit seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0; e = '0; in_tag = '0;
        @(posedge clk); #1;
        chk("rst_y", y, 64'd0);
        chk("rst_tag", 64'(out_tag), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // Basic expression, tag passthrough
        a = 2; b = 3; c = 4; d = 5; e = 7; in_tag = 3; in_valid = 1'b1;
        step(acc);
        chk("t94_acc", 64'(acc), 64'd1);
        in_valid = 1'b0;
        wait_out("t94");
        chk("t94_y", y, 64'd94);
        chk("t94_tag", 64'(out_tag), 64'd3);
        chk("t94_ovf", 64'(out_ovf), 64'd0);
        step(acc);
        chk("t94_clear", 64'(out_valid), 64'd0);

        // a==0 path; live a changes while the op is in flight
        a = 0; b = 9; c = 4; d = 5; e = 7; in_tag = 5; in_valid = 1'b1;
        step(acc);
        in_valid = 1'b0;
        a = 1;
        wait_out("asel");
        chk("asel_y", y, 64'd0);
        chk("asel_ovf", 64'(out_ovf), 64'd0);
        step(acc);

        // All-ones operands
        a = '1; b = '1; c = '1; d = '1; e = '1; in_tag = 6; in_valid = 1'b1;
        step(acc);
        in_valid = 1'b0;
        wait_out("ones");
        chk("ones_y", y, Y_ONES);
        chk("ones_ovf", 64'(out_ovf), 64'd1);
        step(acc);

        // 8 back-to-back ops with a 3-cycle stall at the first result
        issued = 0; stall = 0; seen = 1'b0; ret0 = n_ret;
        rand_ops();
        for (int cyc = 0; cyc < 60 && (n_ret - ret0) < 8; cyc++) begin
            in_valid = (issued < 8);
            in_tag = TW'(issued);
            if (out_valid && !seen) begin
                seen = 1'b1;
                stall = 3;
            end
            out_ready = (stall == 0);
            if (stall > 0) begin
                #1;
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_valid", 64'(out_valid), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("stall_y", y, exp_q[0].y);
                    chk("stall_tag", 64'(out_tag), 64'(exp_q[0].tag));
                end
                stall--;
            end
            step(acc);
            if (acc) begin
                issued++;
                rand_ops();
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("b2b_stalled", 64'(seen), 64'd1);
        chk("b2b_count", 64'(n_ret - ret0), 64'd8);
        chk("b2b_drained", 64'(exp_q.size()), 64'd0);

        // Reset with 3 ops in flight
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            in_valid = 1'b1;
            step(acc);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        exp_q.delete();
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) bad++;
            step(acc);
        end
        chk("mrst_no_out", 64'(bad), 64'd0);
        a = 2; b = 3; c = 4; d = 5; e = 7; in_tag = 9; in_valid = 1'b1;
        step(acc);
        in_valid = 1'b0;
        wait_out("mrst_new");
        chk("mrst_new_y", y, 64'd94);
        step(acc);

        // Toggling in_valid, random out_ready
        ret0 = n_ret;
        issued = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            rand_ops();
            in_valid = cyc[0];
            out_ready = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc) issued++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(acc);
        chk("rand_drained", 64'(exp_q.size()), 64'd0);
        chk("rand_count", 64'(n_ret - ret0), 64'(issued));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipelined_mac_expr.md
PIPELINED_MAC_EXPR -- requirements
Module: pipelined_mac_expr

Interface
REQ-001 SHALL have parameter W, default 32: operand width in bits; legal 8..64.
REQ-002 SHALL have parameter TAG_W, default 4: width of the sideband tag carried alongside each operation.
REQ-003 SHALL have port clk  input  1: single clock; every register is rising-edge triggered.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have ports a, b, c, d, e  input  W each: operands.
REQ-006 SHALL have port in_tag  input  TAG_W: sideband tag, passed through unmodified.
REQ-007 SHALL have ports in_valid  input  1 and in_ready  output  1: input handshake.
REQ-008 SHALL have port y  output  2W: result.
REQ-009 SHALL have port out_tag  output  TAG_W: tag paired with y.
REQ-010 SHALL have port out_ovf  output  1: set if any add or subtract for this result wrapped or clamped.
REQ-011 SHALL have ports out_valid  output  1 and out_ready  input  1: output handshake.
REQ-012 SHALL have port busy  output  1: high when any pipeline stage holds a valid operation.

Function
REQ-013 SHALL accept an operation on every rising edge where in_valid and in_ready are both high.
REQ-014 SHALL compute, with all products full 2W width:
- p1=a*b, p2=c*d
- p3=p1[W-1:0]*e
- s1=p1+p2
- s2=s1+p3
- y = s2+s1 if a!=0, else s2-p2
REQ-015 SHALL truncate each sum and difference to 2W bits (modulo 2^2W) when PMAC_SAT_EN is undefined.
REQ-016 SHALL register the a!=0 select at acceptance and carry it down the pipeline; stage 5 SHALL NOT sample the live a port.
REQ-017 SHALL use five register stages with fixed latency 5: an operation accepted at edge k gives out_valid=1 after edge k+5 when there are no stalls.
- S1: p1, p2
- S2: p3, s1
- S3: s2
- S4: final add or subtract
- S5: output register
REQ-018 SHALL carry a valid bit, tag and ovf bit in every stage alongside the data.
REQ-019 SHALL drive in_ready = !(out_valid && !out_ready), combinationally.
REQ-020 SHALL freeze all stages while out_valid=1 and out_ready=0, holding y, out_tag and out_ovf stable.
REQ-021 SHALL advance the pipeline every cycle while out_valid=0 or out_ready=1; empty stages (bubbles) advance and are not collapsed.
REQ-022 SHALL retire a result and accept a new operation in the same cycle; sustained throughput SHALL be 1 operation per cycle.
REQ-023 SHALL give out_ovf as the OR of the carry-out or borrow of s1, s2 and the stage-4 operation.
REQ-024 SHALL drive busy as the OR of the five stage valid bits.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, clear all stage valid bits and drive y=0, out_tag=0, out_ovf=0, out_valid=0.
REQ-026 SHALL keep in_ready=1 after reset.
REQ-027 SHALL, when rst is asserted mid-operation, discard all in-flight operations with no output produced; reset SHALL take priority over the handshakes.

Configuration
REQ-028 SHALL, when macro PMAC_SAT_EN is defined, saturate as follows:
- s1, s2 and the stage-4 add clamp to 2^2W-1 on carry-out.
- The stage-4 subtract clamps to 0 on borrow.
- Clamped values propagate into later stages.
- out_ovf still reports the clamp.
REQ-029 SHALL, when PMAC_SAT_EN is undefined, wrap as in REQ-015; ports and latency SHALL be identical in both builds.

Verification (W=32, TAG_W=4)
REQ-030 SHALL cover: a=2,b=3,c=4,d=5,e=7, tag=3, out_ready=1 -> 5 cycles later y=94, out_tag=3, out_ovf=0.
REQ-031 SHALL cover: a=0,b=9,c=4,d=5,e=7 -> y=0, out_ovf=0; then a changes to 1 while in flight -> y unchanged (REQ-016).
REQ-032 SHALL cover: a=b=c=d=e=0xFFFFFFFF.
- PMAC_SAT_EN undefined -> y=0xFFFFFFF900000003, out_ovf=1.
- PMAC_SAT_EN defined -> y=0xFFFFFFFFFFFFFFFF, out_ovf=1.
REQ-033 SHALL cover: 8 back-to-back ops with tags 0..7, out_ready=0 for 3 cycles at the first result.
- in_ready=0 during the stall.
- y and out_tag are held during the stall.
- All 8 results arrive in order, with no loss or duplication.
REQ-034 SHALL cover: rst=1 for one cycle with 3 ops in flight -> no out_valid afterwards, busy=0 on the next cycle, and a new op completes with the normal 5-cycle latency.
REQ-035 SHALL cover: in_valid toggling every cycle with random out_ready -> results match a reference model in order, and the in_ready equation (REQ-019) holds every cycle.
